jk_mod_counter: RTL
===================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  parallel-load strobe.
REQ-008 SHALL have port d  input  WIDTH  parallel-load value.
REQ-009 SHALL have port q  output  WIDTH  registered count.
REQ-010 SHALL have port tc  output  1  terminal count, combinational: en & (up_dn ? q==MODULUS-1 : q==0).
REQ-011 SHALL have port ovf  output  1  registered wrap flag: high for exactly one cycle after any wrap.

Function
REQ-012 Per-edge priority SHALL be rst > load > en-count > hold.
REQ-013 With load=1, q SHALL take d on the next edge, regardless of en and up_dn.
REQ-014 With load=1 and d >= MODULUS, q SHALL take MODULUS-1 (clamp); no wrap, ovf=0.
REQ-015 With en=1, up_dn=1 and q < MODULUS-1, q SHALL increment by 1 on the next edge.
REQ-016 With en=1, up_dn=1 and q == MODULUS-1, q SHALL wrap to 0 and ovf SHALL be 1 on the following cycle.
REQ-017 With en=1, up_dn=0 and q > 0, q SHALL decrement by 1 on the next edge.
REQ-018 With en=1, up_dn=0 and q == 0, q SHALL wrap to MODULUS-1 and ovf SHALL be 1 on the following cycle.
REQ-019 With en=0 and load=0, q SHALL hold and ovf SHALL be 0.
REQ-020 Latency from any input to q SHALL be exactly one clock; tc SHALL have zero latency.
REQ-021 A change of up_dn while en=1 SHALL take effect on the very next edge, with no extra cycle.
REQ-022 Each q bit SHALL be stored in a JK cell; per-bit J/K SHALL be derived as follows:
  - load: J=target bit, K=~target bit
  - count: J=K=toggle_i, where toggle_i is 1 iff bit i changes toward the next value; the wrap value is forced via set/reset J/K pairs
  - hold: J=K=0
REQ-023 The next-state J/K logic SHALL use MODULUS-1 and 0 as wrap boundaries; it SHALL never produce a q >= MODULUS.

Reset
REQ-024 While rst=1 at a rising edge, q SHALL become 0 and ovf SHALL become 0, overriding load and en.
REQ-025 Asserting rst mid-count SHALL discard the pending increment; the count SHALL resume from 0 on the first edge after rst deasserts.
REQ-026 tc SHALL follow REQ-010 during reset; with q=0, up_dn=0 and en=1, tc=1.

Structure
REQ-027 A shared package jk_pkg SHALL hold:
  - default WIDTH and MODULUS constants
  - a function computing the next count value
  - a function mapping current and next value to per-bit J/K vectors
REQ-028 A single sub-module jk_cell SHALL be instantiated WIDTH times:
  - ports clk, rst, J, K, Q
  - synchronous active-high reset
  - JK truth table: 00 hold, 01 reset, 10 set, 11 toggle
REQ-029 All other logic SHALL reside in jk_mod_counter; there SHALL be no other clocks and no latches.

Verification
REQ-030 Reset: rst=1 for 2 cycles with load=1, d=7 -> q=0, ovf=0.
REQ-031 Up wrap (MODULUS=10): en=1, up_dn=1 for 12 cycles from 0 -> q = 1..9, 0, 1, 2; tc=1 while q=9; ovf=1 only the cycle q=0 first appears.
REQ-032 Down wrap: en=1, up_dn=0 from q=1 -> q=0, then 9, then 8; tc=1 at q=0; ovf=1 for one cycle with q=9.
REQ-033 Load priority and clamp:
  - load=1, en=1, d=5 -> q=5
  - load=1, d=12 -> q=9, ovf=0
REQ-034 Direction flip: at q=4, en=1, up_dn toggled every cycle -> q=5, 4, 5, 4.
REQ-035 Reset mid-count: at q=6, rst=1 for one edge with en=1 -> q=0, then q=1 on the next edge after rst=0.

Source files
------------

// File: rtl/jk_pkg.sv
//------------------------------------------------------------------------------
// jk_pkg -- shared types, defaults and next-state/J-K mapping functions for
// the JK-cell based modulo up/down counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jk_pkg;

  localparam int c_DEFAULT_WIDTH   = 4;
  localparam int c_DEFAULT_MODULUS = 10;
  // Functions work on a fixed-width word; the counter zero-extends into it.
  localparam int c_MAX_W           = 32;

  typedef logic [c_MAX_W-1:0] jk_word_t;

  typedef enum logic [1:0] {
    JK_HOLD  = 2'd0,
    JK_LOAD  = 2'd1,
    JK_COUNT = 2'd2,
    JK_WRAP  = 2'd3
  } jk_mode_e;

  typedef struct packed {
    jk_word_t j;
    jk_word_t k;
  } jk_vec_t;

  function automatic jk_mode_e jk_mode(
    input logic     load,
    input logic     en,
    input logic     up_dn,
    input jk_word_t cur,
    input jk_word_t max_val
  );
    jk_mode_e m;
    m = JK_HOLD;
    if (load) begin
      m = JK_LOAD;
    end else if (en) begin
      if (up_dn ? (cur == max_val) : (cur == '0)) begin
        m = JK_WRAP;
      end else begin
        m = JK_COUNT;
      end
    end
    return m;
  endfunction

  function automatic jk_word_t jk_next(
    input jk_mode_e mode,
    input logic     up_dn,
    input jk_word_t cur,
    input jk_word_t d,
    input jk_word_t max_val
  );
    jk_word_t n;
    n = cur;
    case (mode)
      JK_LOAD:  n = (d > max_val) ? max_val : d;
      JK_COUNT: n = up_dn ? (cur + jk_word_t'(1)) : (cur - jk_word_t'(1));
      JK_WRAP:  n = up_dn ? '0 : max_val;
      default:  n = cur;
    endcase
    return n;
  endfunction

  // Load and wrap drive explicit set/reset pairs; counting toggles only the
  // bits that differ between the current and next value.
  function automatic jk_vec_t jk_map(
    input jk_mode_e mode,
    input jk_word_t cur,
    input jk_word_t nxt
  );
    jk_vec_t v;
    v.j = '0;
    v.k = '0;
    case (mode)
      JK_LOAD, JK_WRAP: begin
        v.j = nxt;
        v.k = ~nxt;
      end
      JK_COUNT: begin
        v.j = cur ^ nxt;
        v.k = cur ^ nxt;
      end
      default: begin
        v.j = '0;
        v.k = '0;
      end
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
//------------------------------------------------------------------------------
// jk_cell -- single JK flip-flop with synchronous active-high reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/jk_mod_counter.sv
//------------------------------------------------------------------------------
// jk_mod_counter -- loadable modulo-N up/down counter built from JK cells,
// with combinational terminal count and a one-cycle registered wrap flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = c_DEFAULT_WIDTH,
  parameter int MODULUS = c_DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam jk_word_t         c_MAX_VAL = jk_word_t'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  jk_word_t         w_cur;
  jk_word_t         w_d;
  jk_word_t         w_nxt;
  jk_mode_e         w_mode;
  logic             w_wrap;
  logic             r_ovf;

  assign w_cur  = jk_word_t'(w_q);
  assign w_d    = jk_word_t'(d);
  assign w_mode = jk_mode(load, en, up_dn, w_cur, c_MAX_VAL);
  assign w_nxt  = jk_next(w_mode, up_dn, w_cur, w_d, c_MAX_VAL);
  assign w_wrap = (w_mode == JK_WRAP);

  // Packed {j,k}: the upper half carries J, the lower half K.
  assign w_j = WIDTH'(jk_map(w_mode, w_cur, w_nxt) >> c_MAX_W);
  assign w_k = WIDTH'(jk_map(w_mode, w_cur, w_nxt));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .J   (w_j[gi]),
      .K   (w_k[gi]),
      .Q   (w_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_wrap;
    end
  end

  assign q   = w_q;
  assign ovf = r_ovf;
  assign tc  = en & (up_dn ? (w_q == c_MAX_Q) : (w_q == '0));

endmodule

`default_nettype wire
